// File: rtl/piso_serializer_pkg.sv
// piso_pkg: shared state type, idle level and counter sizing for piso_serializer
package piso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    localparam logic IDLE_LEVEL = 1'b0;
    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction
endpackage

// File: rtl/piso_serializer_bit_tick.sv
// bit_tick: bit-period counter; tick marks the last cycle of each serial bit
module bit_tick import piso_pkg::*; #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first valid/ready serializer; PISO_PARITY_EN appends an even-parity bit
module piso_serializer import piso_pkg::*; #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(WIDTH);
    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic             so_n, busy_n, done_n, tick;
    assign ready = state == IDLE;
    bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (ready),
        .tick (tick)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            serial_out <= IDLE_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            bit_cnt    <= bit_n;
            serial_out <= so_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end
    // The captured word stays intact so parity can be taken over all of it.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        bit_n   = bit_cnt;
        so_n    = serial_out;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: if (load) begin
                state_n = SHIFT;
                sreg_n  = data_in;
                so_n    = data_in[WIDTH-1];
                bit_n   = BW'(WIDTH - 1);
                busy_n  = 1'b1;
            end
            SHIFT: if (tick) begin
                if (bit_cnt == '0) begin
`ifdef PISO_PARITY_EN
                    state_n = PARITY;
                    so_n    = ^sreg;
`else
                    state_n = IDLE;
                    so_n    = IDLE_LEVEL;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
`endif
                end else begin
                    bit_n = bit_cnt - 1'b1;
                    so_n  = sreg[bit_cnt - 1'b1];
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: if (tick) begin
                state_n = IDLE;
                so_n    = IDLE_LEVEL;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: random and directed checks of two serializer instances (1 and 3 clocks per bit)
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    logic       clk = 0, rst = 1, ld = 0;
    logic [3:0] din = '0;
    logic [1:0] so, bsy, dn, rdy;
    int         n_cmp = 0, n_err = 0;
    bit         act[2];
    int         t[2];
    logic [3:0] w[2];
    logic [3:0] q1;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(din), .load(ld),
        .ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]), .done(dn[0]));
    piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(3)) dut3 (
        .clk(clk), .rst(rst), .data_in(din), .load(ld),
        .ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]), .done(dn[1]));

    function automatic int cpb(input int k);
        return (k == 0) ? 1 : 3;
    endfunction
    function automatic int nc(input int k);
        return (4 + PAR) * cpb(k);
    endfunction
    function automatic logic fbit(input logic [3:0] word, input int j);
        return (j < 4) ? word[3 - j] : ^word;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame timeline model: t counts cycles since the accepting edge.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                act[k] <= 1'b0;
                t[k]   <= 0;
            end else if ((!act[k] || t[k] == nc(k)) && ld) begin
                act[k] <= 1'b1;
                t[k]   <= 0;
                w[k]   <= din;
            end else if (act[k]) begin
                t[k] <= t[k] + 1;
                if (t[k] >= nc(k)) act[k] <= 1'b0;
            end
        end
    end

    always @(posedge clk or posedge rst) q1 <= rst ? 4'h0 : {q1[2:0], so[0]};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic in_frame;
            in_frame = act[k] && t[k] < nc(k);
            check($sformatf("serial%0d", k), 32'(so[k]), in_frame ? 32'(fbit(w[k], t[k] / cpb(k))) : 32'd0);
            check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(in_frame));
            check($sformatf("done%0d", k), 32'(dn[k]), 32'(act[k] && t[k] == nc(k)));
            check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!act[k] || t[k] == nc(k)));
        end
        if (act[0] && t[0] == 4) check("downstream_q", 32'(q1), 32'(w[0]));
    end

    task automatic send(input logic [3:0] d, input int gap);
        @(negedge clk);
        ld  = 1'b1;
        din = d;
        @(negedge clk);
        ld  = 1'b0;
        din = 4'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(4'b1011, 16);
        send(4'b1100, 2);
        send(4'b0110, 16);
        send(4'b0001, 0);
        send(4'b1111, 16);
        send(4'b1010, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_serial0", 32'(so[0]), 32'd0);
        check("async_rst_serial1", 32'(so[1]), 32'd0);
        check("async_rst_busy1", 32'(bsy[1]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(4'b0111, 20);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            ld  = ($urandom_range(0, 3) == 0);
            din = 4'($urandom);
        end
        @(negedge clk);
        ld = 1'b0;
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter that takes a WIDTH-bit word on a valid/ready handshake and drives it MSB-first onto a single serial line. It sits directly upstream of the 4-bit serial-in shift register. `serial_out` wires straight to that register's `serial_in`. With WIDTH=4 and CLKS_PER_BIT=1, the register's `q` equals the loaded word exactly WIDTH clocks after acceptance. A bit-period counter lets the same block feed slower consumers.

## Interface
- `WIDTH`, default 4: data word width; must be ≥ 2.
- `CLKS_PER_BIT`, default 1: clock cycles each serial bit is held; must be ≥ 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `data_in`  in  WIDTH: word to transmit; sampled only on an accepted load.
- `load`  in  1: request to transmit `data_in`.
- `ready`  out  1: block can accept a load; combinational, high only in IDLE.
- `serial_out`  out  1: registered serial data; idle level is 0.
- `busy`  out  1: registered; high while a frame is being shifted.
- `done`  out  1: registered one-cycle pulse when a frame completes.

## Operation
- States: IDLE, SHIFT, plus PARITY when the parity feature is compiled in.
- IDLE:
  - `ready`=1, `serial_out`=0, `busy`=0.
  - `load` && `ready` accepts the load. On that edge: capture `data_in` into the shift register, set `serial_out` ← `data_in[WIDTH-1]`, set `bit_cnt` ← WIDTH-1, clear `tick_cnt`, set `busy` ← 1, and go to SHIFT.
- SHIFT:
  - `tick_cnt` counts 0..CLKS_PER_BIT-1. On wrap, the next bit goes out MSB→LSB and `bit_cnt` decrements.
  - On wrap with `bit_cnt`=0, the last data bit has been held a full period:
    - With parity: go to PARITY and set `serial_out` ← XOR of the captured word (even parity).
    - Without parity: go to IDLE, set `serial_out` ← 0, `busy` ← 0, `done` ← 1.
- PARITY: hold the parity bit for CLKS_PER_BIT cycles, then go to IDLE with `serial_out` ← 0, `busy` ← 0, `done` ← 1.
- `load` while not in IDLE is ignored; the in-flight frame and the captured word are unaffected.
- `data_in` changes after acceptance have no effect.
- `done` is high for exactly one cycle, the first IDLE cycle. `ready` is also high in that cycle, so a new load may be accepted there.
- Reset, at any time including mid-frame: state=IDLE, `serial_out`=0, `busy`=0, `done`=0, `bit_cnt`=0, `tick_cnt`=0, shift register=0. The partial frame is discarded.

## Timing
- Load accepted at edge E: the MSB is valid on `serial_out` from E through E+CLKS_PER_BIT.
- Bit i (i=0 is the MSB) is valid on `serial_out` during [E+i·CLKS_PER_BIT, E+(i+1)·CLKS_PER_BIT).
- Frame length N = WIDTH, or WIDTH+1 with parity. Return to IDLE and the `done` pulse occur at edge E+N·CLKS_PER_BIT.
- Minimum load-to-load spacing is N·CLKS_PER_BIT cycles: a back-to-back load is accepted in the `done` cycle.
- Downstream register (CLKS_PER_BIT=1, no parity): it samples bit i at edge E+i+1, so its `q` equals the word after edge E+WIDTH.

## Configuration
- Macro `PISO_PARITY_EN`:
  - Defined: PARITY state is present and an even-parity bit is appended after the LSB; frame = WIDTH+1 bits.
  - Undefined: PARITY state and parity logic are absent; frame = WIDTH bits; `done` follows the LSB directly.

## Structure
- Package `piso_pkg`:
  - state typedef (IDLE, SHIFT, PARITY);
  - idle-level constant (0);
  - helper function for the counter width, `$clog2(CLKS_PER_BIT)` clamped to ≥ 1.
- Sub-module `bit_tick`: parameterised CLKS_PER_BIT counter with synchronous clear and a `tick` output that marks the last cycle of each bit period. The top module holds the FSM, shift register and bit counter.

## Test plan
- Reset then idle (WIDTH=4, CLKS_PER_BIT=1): hold `rst`=1 for 2 cycles, then release → `serial_out`=0, `busy`=0, `done`=0, `ready`=1.
- Load 4'b1011 → `serial_out` = 1,0,1,1 on four consecutive cycles. Chained shift register `q`=1011 after the 4th edge. `done`=1 for one cycle at E+4, then `serial_out`=0.
- Back-to-back: load 4'b1100, then load 4'b0110 in the `done` cycle → continuous stream 1,1,0,0,0,1,1,0 with no gap. Exactly two `done` pulses.
- Load ignored while busy: pulse `load` with 4'b1111 two cycles into a 4'b0001 frame → stream 0,0,0,1 unchanged; only one `done` pulse.
- Reset mid-frame: assert `rst` after 2 bits of 4'b1010 → `serial_out`=0 immediately (asynchronously); no `done` pulse. After release, `ready`=1.
- CLKS_PER_BIT=3 with `PISO_PARITY_EN`: load 4'b0111 → each of 0,1,1,1 and then parity 1 is held 3 cycles. `done` is asserted at E+15.
